axis_stream_rxfifo: RTL and testbench

AXIS_STREAM_RXFIFO -- requirements
Module: axis_stream_rxfifo

---
 rtl/axis_stream_rxfifo.sv | 133 +++++++++++++
 tb/tb_axis_stream_rxfifo.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_stream_rxfifo.sv
// Three-channel lockstep AXI-Stream frame capture buffer, drained as one serial stream.
// Optional build macro: RXFIFO_TLAST_PER_CHANNEL_EN (tlast at the end of every channel block).
module axis_stream_rxfifo #(
  parameter int unsigned C_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned FRAME_LOG2         = 11
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            arm,
  output logic                            busy,
  output logic                            done,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic                            s00_axis_tvalid,
  output logic                            s00_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s01_axis_tdata,
  input  logic                            s01_axis_tvalid,
  output logic                            s01_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s02_axis_tdata,
  input  logic                            s02_axis_tvalid,
  output logic                            s02_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                            m00_axis_tvalid,
  input  logic                            m00_axis_tready,
  output logic                            m00_axis_tlast
);

  localparam int unsigned DW    = C_AXIS_TDATA_WIDTH;
  localparam int unsigned SW    = C_AXIS_TDATA_WIDTH / 8;
  localparam int unsigned AW    = FRAME_LOG2 + 2;
  localparam int unsigned N     = 1 << FRAME_LOG2;
  localparam int unsigned DEPTH = 3 * N;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t          state;
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   rd_addr;
  logic [DW-1:0]   mem [DEPTH];

  logic accept;
  logic load;
  logic out_hs;
  logic final_hs;
  logic last_word;

  // All three channels advance together or not at all
  assign accept          = (state == CAPTURE) & s00_axis_tvalid & s01_axis_tvalid & s02_axis_tvalid;
  assign s00_axis_tready = accept;
  assign s01_axis_tready = accept;
  assign s02_axis_tready = accept;

  assign out_hs   = m00_axis_tvalid & m00_axis_tready;
  // The memory read register doubles as the output stage; refill whenever it empties or is consumed
  assign load     = (state == DRAIN) && (rd_addr != AW'(DEPTH)) && (!m00_axis_tvalid || m00_axis_tready);
  assign final_hs = (state == DRAIN) && out_hs && (rd_addr == AW'(DEPTH));

`ifdef RXFIFO_TLAST_PER_CHANNEL_EN
  assign last_word = (rd_addr == AW'(N - 1)) || (rd_addr == AW'(2 * N - 1)) || (rd_addr == AW'(DEPTH - 1));
`else
  assign last_word = (rd_addr == AW'(DEPTH - 1));
`endif

  // Sample storage, channel-major blocks; never cleared by reset
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_idx]               <= s00_axis_tdata;
      mem[AW'(N) + wr_idx]      <= s01_axis_tdata;
      mem[AW'(2 * N) + wr_idx]  <= s02_axis_tdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      wr_idx          <= '0;
      rd_addr         <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      m00_axis_tdata  <= '0;
      m00_axis_tstrb  <= '0;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tlast  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (arm) begin
            state  <= CAPTURE;
            busy   <= 1'b1;
            wr_idx <= '0;
          end
        end
        CAPTURE: begin
          if (accept) begin
            wr_idx <= wr_idx + AW'(1);
            if (wr_idx == AW'(N - 1)) begin
              state   <= DRAIN;
              rd_addr <= '0;
            end
          end
        end
        DRAIN: begin
          if (load) begin
            m00_axis_tdata  <= mem[rd_addr];
            m00_axis_tlast  <= last_word;
            m00_axis_tvalid <= 1'b1;
            m00_axis_tstrb  <= {SW{1'b1}};
            rd_addr         <= rd_addr + AW'(1);
          end else if (out_hs) begin
            m00_axis_tvalid <= 1'b0;
            m00_axis_tlast  <= 1'b0;
            m00_axis_tstrb  <= '0;
          end
          if (final_hs) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_stream_rxfifo.sv
// Scoreboard bench for axis_stream_rxfifo with FRAME_LOG2=3 (N=8, 24 words per frame).
// Honours RXFIFO_TLAST_PER_CHANNEL_EN to predict tlast placement.
module tb_axis_stream_rxfifo;

  localparam int unsigned N = 8;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        first;
    logic        fin;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arm = 1'b0;
  logic        busy, done;
  logic [31:0] s00_tdata = '0, s01_tdata = '0, s02_tdata = '0;
  logic        s00_tvalid = 1'b0, s01_tvalid = 1'b0, s02_tvalid = 1'b0;
  logic        s00_tready, s01_tready, s02_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tstrb;
  logic        m_tvalid, m_tlast;
  logic        m_tready = 1'b1;

  int   checks = 0;
  int   errors = 0;
  int   tr_mode = 0;
  int   cyc_cnt = 0;
  int   hs_count = 0;
  int   frames_done = 0;
  int   first_cyc = 0;
  int   span = 0;
  bit   pend_done = 1'b0;
  bit   flushing = 1'b1;
  exp_t exp_q[$];

  axis_stream_rxfifo #(
    .C_AXIS_TDATA_WIDTH(32),
    .FRAME_LOG2(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .arm(arm),
    .busy(busy),
    .done(done),
    .s00_axis_tdata(s00_tdata),
    .s00_axis_tvalid(s00_tvalid),
    .s00_axis_tready(s00_tready),
    .s01_axis_tdata(s01_tdata),
    .s01_axis_tvalid(s01_tvalid),
    .s01_axis_tready(s01_tready),
    .s02_axis_tdata(s02_tdata),
    .s02_axis_tvalid(s02_tvalid),
    .s02_axis_tready(s02_tready),
    .m00_axis_tdata(m_tdata),
    .m00_axis_tstrb(m_tstrb),
    .m00_axis_tvalid(m_tvalid),
    .m00_axis_tready(m_tready),
    .m00_axis_tlast(m_tlast)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Downstream ready pattern: 0 = always, 1 = alternating, 2 = random
  always @(posedge clk) begin
    #1;
    case (tr_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ~m_tready;
      default: m_tready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops the scoreboard on every output handshake
  always @(negedge clk) begin
    exp_t e;
    if (!flushing) begin
      if (pend_done) begin
        chk("done_pulse", {61'd0, done, m_tvalid, busy}, 64'b100);
        pend_done = 1'b0;
        frames_done++;
      end else if (done === 1'b1) begin
        chk("spurious_done", 64'(done), 64'd0);
      end
      if (m_tvalid === 1'b1) chk("tstrb", 64'(m_tstrb), 64'hf);
      if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 64'(m_tdata), 64'hdead_beef);
        end else begin
          e = exp_q.pop_front();
          chk("tdata", 64'(m_tdata), 64'(e.data));
          chk("tlast", 64'(m_tlast), 64'(e.last));
          if (e.first) first_cyc = cyc_cnt;
          if (e.fin) begin
            span = cyc_cnt - first_cyc;
            pend_done = 1'b1;
          end
        end
      end
    end
  end

  task automatic push_frame(input logic [31:0] base);
    exp_t e;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < int'(N); i++) begin
        e.data  = base + 32'h100 * 32'(c + 1) + 32'(i);
`ifdef RXFIFO_TLAST_PER_CHANNEL_EN
        e.last  = (i == int'(N) - 1);
`else
        e.last  = (c == 2) && (i == int'(N) - 1);
`endif
        e.first = (c == 0) && (i == 0);
        e.fin   = (c == 2) && (i == int'(N) - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // Arm, then feed N lockstep beats; s01 drops valid for one cycle at beat gap_at
  task automatic run_frame(input logic [31:0] base, input int gap_at);
    int  i = 0;
    int  n = 0;
    bit  acc;
    bit  gapped = 1'b0;
    push_frame(base);
    hs_count = 0;
    arm = 1'b1;
    while (i < int'(N) && n < 200) begin
      s00_tdata  = base + 32'h100 + 32'(i);
      s01_tdata  = base + 32'h200 + 32'(i);
      s02_tdata  = base + 32'h300 + 32'(i);
      s00_tvalid = 1'b1;
      s02_tvalid = 1'b1;
      s01_tvalid = !(i == gap_at && !gapped);
      @(negedge clk);
      acc = s00_tready;
      if (i == gap_at && !gapped) begin
        chk("gap_tready", {61'd0, s00_tready, s01_tready, s02_tready}, 64'd0);
        gapped = 1'b1;
      end
      @(posedge clk);
      #1;
      arm = 1'b0;
      if (acc) i++;
      n++;
    end
    s00_tvalid = 1'b0;
    s01_tvalid = 1'b0;
    s02_tvalid = 1'b0;
    if (i < int'(N)) chk("capture_timeout", 64'(i), 64'(N));
  endtask

  task automatic wait_frame();
    int start = frames_done;
    int n = 0;
    while (frames_done == start && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("frame_complete", 64'(frames_done - start), 64'd1);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int n;
    // Reset with all upstream valids high
    s00_tvalid = 1'b1;
    s01_tvalid = 1'b1;
    s02_tvalid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_tready", {61'd0, s00_tready, s01_tready, s02_tready}, 64'd0);
    chk("rst_mout", {26'd0, m_tdata, m_tstrb, m_tvalid, m_tlast}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    s00_tvalid = 1'b0;
    s01_tvalid = 1'b0;
    s02_tvalid = 1'b0;
    flushing = 1'b0;
    @(posedge clk);
    #1;

    // Basic frame with sink always ready; checks back-to-back throughput
    tr_mode = 0;
    run_frame(32'h0, -1);
    wait_frame();
    chk("sustain_span", 64'(span), 64'd23);

    // One-cycle s01 bubble mid capture
    run_frame(32'h0, 3);
    wait_frame();

    // Alternating and random backpressure
    tr_mode = 1;
    run_frame(32'h4000, -1);
    wait_frame();
    tr_mode = 2;
    run_frame(32'h5000, 5);
    wait_frame();

    // arm while draining must be ignored
    tr_mode = 0;
    run_frame(32'h6000, -1);
    n = 0;
    while (m_tvalid !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    arm = 1'b1;
    @(posedge clk);
    #1;
    arm = 1'b0;
    wait_frame();
    @(negedge clk);
    chk("arm_ignored_busy", 64'(busy), 64'd0);

    // Reset in the middle of the drain
    @(posedge clk);
    #1;
    tr_mode = 2;
    run_frame(32'h7000, -1);
    n = 0;
    while (hs_count < 5 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_progress", 64'(hs_count >= 5), 64'd1);
    rst = 1'b1;
    flushing = 1'b1;
    exp_q.delete();
    pend_done = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_tvalid", 64'(m_tvalid), 64'd0);
    chk("midrst_busy", {62'd0, busy, done}, 64'd0);
    chk("midrst_mout", {26'd0, m_tdata, m_tstrb, m_tvalid, m_tlast}, 64'd0);
    @(posedge clk);
    #1;
    flushing = 1'b0;

    // Fresh frame after the aborted one
    tr_mode = 2;
    run_frame(32'h8000, 2);
    wait_frame();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d expected=0", cyc_cnt);
    $fatal(1, "timeout");
  end

endmodule
